// File: rtl/btn_pkg.sv
// Shared definitions for the push-button chain: classifier states, default
// timing constants and a small elaboration-time helper.
package btn_pkg;

  localparam int unsigned LONG_CYCLES_DEF = 1000;
  localparam int unsigned DOUBLE_GAP_DEF  = 250;

  typedef enum logic [2:0] {
    WAIT_REL = 3'd0,
    IDLE     = 3'd1,
    PRESS1   = 3'd2,
    WAIT2    = 3'd3,
    PRESS2   = 3'd4
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_cycle_counter.sv
// Loadable up-counter with a terminal-compare output, shared by all
// press_classifier states.
module btn_cycle_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term_val,
  output logic [W-1:0] o_count,
  output logic         o_term
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == i_term_val);

endmodule

// File: rtl/press_classifier.sv
// Turns the debounced button level into one-cycle short / double / long
// press pulses for the control FSMs.
module press_classifier
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int unsigned DOUBLE_GAP  = DOUBLE_GAP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic busy
);

  localparam int unsigned CW = $clog2(max_u(LONG_CYCLES, DOUBLE_GAP)) + 1;
  localparam logic [CW-1:0] LONG_TERM = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_TERM  = CW'(DOUBLE_GAP - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  state_t        r_state;
  state_t        w_next;
  logic          r_short, r_double, r_long, r_busy;
  logic          w_short, w_double, w_long;
  logic          w_load, w_en, w_term;
  logic [CW-1:0] w_load_val, w_term_val, w_ctr;

  // Only PRESS1 and WAIT2 consult the terminal compare; select its bound by state.
  assign w_term_val = (r_state == PRESS1) ? LONG_TERM : GAP_TERM;

  btn_cycle_counter #(.W(CW)) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .i_term_val (w_term_val),
    .o_count    (w_ctr),
    .o_term     (w_term)
  );

  always_comb begin
    w_next   = r_state;
    w_short  = 1'b0;
    w_double = 1'b0;
    w_long   = 1'b0;
    w_en     = 1'b0;
    case (r_state)
      WAIT_REL: if (!level) w_next = IDLE;
      IDLE:     if (level)  w_next = PRESS1;
      PRESS1: begin
        if (!level) begin
          w_next = WAIT2;
        end else if (w_term) begin
          w_long = 1'b1;
          w_next = WAIT_REL;
        end else begin
          w_en = 1'b1;
        end
      end
      WAIT2: begin
        if (level) begin
          w_next = PRESS2;
        end else if (w_term) begin
          w_short = 1'b1;
          w_next  = IDLE;
        end else begin
          w_en = 1'b1;
        end
      end
      PRESS2: begin
        if (!level) begin
          w_double = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = WAIT_REL;
    endcase
  end

  // Counter is reloaded on every state change, so it can never wrap.
  assign w_load     = (w_next != r_state);
  assign w_load_val = ((w_next == PRESS1) || (w_next == WAIT2)) ? ONE : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= WAIT_REL;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_short  <= w_short;
      r_double <= w_double;
      r_long   <= w_long;
      r_busy   <= (w_next != IDLE);
    end
  end

  assign short_press  = r_short;
  assign double_press = r_double;
  assign long_press   = r_long;
  assign busy         = r_busy;

endmodule
